varint_zz_encoder: RTL and testbench



---
 rtl/varint_pkg.sv | 12 +
 rtl/varint_zz_map.sv | 25 ++
 rtl/varint_zz_encoder.sv | 56 +++++
 tb/tb_varint_zz_encoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/varint_pkg.sv
// Shared widths and types for the protobuf varint encoder slice.
package varint_pkg;

  localparam int unsigned VARINT_MAX_BYTES = 10;
  localparam int unsigned VALUE_W          = 64;
  localparam int unsigned VARINT_W         = 80;
  localparam int unsigned GROUP_W          = 7;
  localparam int unsigned PAD_W            = GROUP_W * VARINT_MAX_BYTES;

  typedef logic [VARINT_W-1:0] varint_t;

endpackage

// File: rtl/varint_zz_map.sv
// Combinational pre-map: optional ZigZag and 32-bit field masking.
module varint_zz_map
  import varint_pkg::*;
(
  input  logic [VALUE_W-1:0] in_val,
  input  logic               zz_en,
  input  logic               is_32,
  output logic [VALUE_W-1:0] mapped
);

  logic [31:0] lo;

  assign lo = in_val[31:0];

  always_comb begin
    mapped = in_val;
    case ({zz_en, is_32})
      2'b11:   mapped = {32'b0, {lo[30:0], 1'b0} ^ {32{lo[31]}}};
      2'b10:   mapped = {in_val[62:0], 1'b0} ^ {64{in_val[63]}};
      2'b01:   mapped = {32'b0, lo};
      default: mapped = in_val;
    endcase
  end

endmodule

// File: rtl/varint_zz_encoder.sv
// Registered protobuf varint encoder: one 64-bit value per cycle in,
// 10-byte little-endian base-128 image plus byte count out one cycle later.
module varint_zz_encoder
  import varint_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [VALUE_W-1:0] in_val,
  input  logic               zz_en,
  input  logic               is_32,
  output logic               out_valid,
  output varint_t            out_bytes,
  output logic [3:0]         out_len
);

  logic [VALUE_W-1:0] v;
  logic [PAD_W-1:0]   vp;
  varint_t            enc;
  logic [3:0]         len;

  varint_zz_map u_map (
    .in_val (in_val),
    .zz_en  (zz_en),
    .is_32  (is_32),
    .mapped (v)
  );

  // Zero-pad to 70 bits so byte 9 falls out as a regular 7-bit group
  always_comb begin
    vp  = {(PAD_W - VALUE_W)'(0), v};
    enc = '0;
    len = 4'd1;
    for (int unsigned i = 0; i < VARINT_MAX_BYTES; i++) begin
      if (i == 0 || (vp >> (GROUP_W * i)) != '0)
        enc[8*i +: 8] = {(vp >> (GROUP_W * (i + 1))) != '0, vp[GROUP_W*i +: GROUP_W]};
      if (vp[GROUP_W*i +: GROUP_W] != '0)
        len = 4'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_bytes <= '0;
      out_len   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_bytes <= enc;
        out_len   <= len;
      end
    end
  end

endmodule

// File: tb/tb_varint_zz_encoder.sv
// Scoreboard bench for varint_zz_encoder using hand-computed directed vectors.
module tb_varint_zz_encoder;
  import varint_pkg::*;

  typedef struct packed {
    logic [79:0] b;
    logic [3:0]  l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_val;
  logic        zz_en;
  logic        is_32;
  logic        out_valid;
  varint_t     out_bytes;
  logic [3:0]  out_len;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  varint_zz_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_val    (in_val),
    .zz_en     (zz_en),
    .is_32     (is_32),
    .out_valid (out_valid),
    .out_bytes (out_bytes),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: bytes %h len %0d with empty scoreboard", out_bytes, out_len);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_bytes", out_bytes, e.b);
        chk("out_len", 80'(out_len), 80'(e.l));
      end
    end
  end

  task automatic send(input logic [63:0] val, input logic zz, input logic s32,
                      input logic [79:0] eb, input logic [3:0] el);
    exp_t e;
    e.b = eb;
    e.l = el;
    in_valid = 1'b1;
    in_val   = val;
    zz_en    = zz;
    is_32    = s32;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_val   = '0;
    zz_en    = 1'b0;
    is_32    = 1'b0;
    #1;
    chk("reset_valid", 80'(out_valid), 80'(0));
    chk("reset_bytes", out_bytes, 80'(0));
    chk("reset_len", 80'(out_len), 80'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    send(64'd300, 1'b0, 1'b0, 80'h02AC, 4'd2);
    send(64'd0, 1'b0, 1'b0, 80'h00, 4'd1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 4'd10);
    send(64'h8000_0000_0000_0000, 1'b0, 1'b0, 80'h01_8080_8080_8080_8080_80, 4'd10);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 80'h01, 4'd1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 80'h0F_FFFF_FFFF, 4'd5);
    send(64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1, 80'h0F_FFFF_FFFE, 4'd5);
    send(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 80'h03, 4'd1);
    send(64'd127, 1'b0, 1'b0, 80'h7F, 4'd1);
    send(64'd300, 1'b0, 1'b0, 80'h02AC, 4'd2);
    send(64'd1, 1'b0, 1'b0, 80'h01, 4'd1);
    send(64'd128, 1'b0, 1'b0, 80'h0180, 4'd2);

    // Idle cycle: valid drops, data holds the last encoding
    @(posedge clk);
    @(negedge clk);
    chk("idle_valid", 80'(out_valid), 80'(0));
    chk("hold_bytes", out_bytes, 80'h0180);
    chk("hold_len", 80'(out_len), 80'(2));
    drain();

    // Reset between edges with a request pending
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_val   = 64'd5;
    zz_en    = 1'b0;
    is_32    = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 80'(out_valid), 80'(0));
    chk("async_bytes", out_bytes, 80'(0));
    chk("async_len", 80'(out_len), 80'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rst_hold_bytes", out_bytes, 80'(0));
    chk("rst_hold_valid", 80'(out_valid), 80'(0));
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(64'd150, 1'b0, 1'b0, 80'h0196, 4'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
